// File: rtl/fd_skid_pipe_reg.sv
// rtl/fd_skid_pipe_reg.sv - fetch->decode skid pipeline register, optional PIPE_STALL_CNT_EN stall counter
module fd_skid_pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_acc;
    logic             out_acc;

    assign in_acc    = in_valid & in_ready_q;
    assign out_acc   = out_valid_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    // in_ready and out_valid are kept as flops alongside the state so that
    // neither handshake output has combinational paths from the inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= ST_EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_acc) begin
                        main_q      <= in_data;
                        state       <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_acc && out_acc) begin
                        main_q <= in_data;
                    end else if (in_acc) begin
                        skid_q     <= in_data;
                        state      <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_acc) begin
                        main_q      <= NOP_VALUE;
                        state       <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_acc) begin
                        main_q     <= skid_q;
                        state      <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    main_q      <= NOP_VALUE;
                    skid_q      <= NOP_VALUE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Flush cycles still count: decode was stalled in that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
